// File: rtl/opl3_reg_wr_sched.sv
// opl3_reg_wr_sched: single driver of the OPL3 register-write bus.
// Arbitrates between a host write port and an internal full-clear sweep,
// and spaces issued writes by at least MIN_GAP idle cycles.
`timescale 1ns/1ps

package opl3_pkg;
    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;
endpackage

module opl3_reg_wr_sched
    import opl3_pkg::*;
#(
    parameter int MIN_GAP        = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         host_valid,
    output logic         host_ready,
    input  logic         host_bank_num,
    input  logic [7:0]   host_address,
    input  logic [7:0]   host_data,
    input  logic         clear_req,
    output logic         clear_active,
    output opl3_reg_wr_t opl3_reg_wr
);

    localparam int              CNT_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(MIN_GAP);

    // BOOT is the reset state; it lasts until the first edge after release so
    // that nothing is issued or accepted while reset is still settling.
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [8:0]   sweep_idx;
    logic [8:0]   sweep_nxt;
    logic [CNT_W-1:0] cnt;
    logic         slot_p0;
    opl3_reg_wr_t wr_p0;
    opl3_reg_wr_t wr_p1;

    // Stage p0: issue decision from registered state only.
    // With a nonzero gap, cnt==0 already implies no pulse is on the bus; the
    // explicit valid term keeps the rule exact for every MIN_GAP.
    assign slot_p0 = (cnt == '0) && ((MIN_GAP == 0) || !wr_p1.valid);

    // Next-state, sweep index, arbitration and handshake outputs.
    always_comb begin
        state_nxt    = state;
        sweep_nxt    = sweep_idx;
        wr_p0        = '0;
        host_ready   = 1'b0;
        clear_active = (state == ST_CLEAR) || ((state == ST_BOOT) && CLEAR_ON_RESET);
        case (state)
            ST_BOOT: begin
                if (CLEAR_ON_RESET || clear_req) begin
                    state_nxt = ST_CLEAR;
                    sweep_nxt = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                host_ready = slot_p0;
                if (slot_p0 && host_valid) begin
                    wr_p0.valid    = 1'b1;
                    wr_p0.bank_num = host_bank_num;
                    wr_p0.address  = host_address;
                    wr_p0.data     = host_data;
                end
                // A clear request alongside a host handshake still lets the
                // host write go out; the sweep takes the following slot.
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                    sweep_nxt = '0;
                end
            end
            ST_CLEAR: begin
                // Requests arriving mid-sweep are dropped: no restart, no queue.
                if (slot_p0) begin
                    wr_p0.valid    = 1'b1;
                    wr_p0.bank_num = sweep_idx[8];
                    wr_p0.address  = sweep_idx[7:0];
                    wr_p0.data     = 8'h00;
                    sweep_nxt      = sweep_idx + 9'd1;
                    if (sweep_idx == 9'h1FF) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // State and sweep index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_BOOT;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_nxt;
        end
    end

    // Gap counter: holds MIN_GAP in the cycle a pulse is on the bus, then counts down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (wr_p0.valid) begin
            cnt <= GAP_LD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Stage p1: registered write bus; idle cycles carry all-zero fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_p1 <= '0;
        end else begin
            wr_p1 <= wr_p0;
        end
    end

    assign opl3_reg_wr = wr_p1;

endmodule

// File: tb/tb_opl3_reg_wr_sched.sv
// Testbench for opl3_reg_wr_sched: two instances (gap 3 with clear on reset,
// gap 0 without), a cycle-level reference model, a vector table and
// directed sequences for the sweep / reset corner cases.
`timescale 1ns/1ps

module tb_opl3_reg_wr_sched;
    import opl3_pkg::*;

    typedef struct {
        logic       b;
        logic [7:0] a;
        logic [7:0] d;
    } hw_t;

    typedef struct {
        logic       b;
        logic [7:0] a;
        logic [7:0] d;
        logic       ev;
        logic       eb;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       erdy;
    } vec_t;

    logic clk;
    logic rst0, rst1;
    logic hv0, hb0, creq0, hv1, hb1, creq1;
    logic [7:0] ha0, hd0, ha1, hd1;
    logic rdy0, act0, rdy1, act1;
    opl3_reg_wr_t wr0, wr1;

    opl3_reg_wr_sched #(.MIN_GAP(3), .CLEAR_ON_RESET(1'b1)) u0 (
        .clk(clk), .reset_n(rst0), .host_valid(hv0), .host_ready(rdy0),
        .host_bank_num(hb0), .host_address(ha0), .host_data(hd0),
        .clear_req(creq0), .clear_active(act0), .opl3_reg_wr(wr0)
    );

    opl3_reg_wr_sched #(.MIN_GAP(0), .CLEAR_ON_RESET(1'b0)) u1 (
        .clk(clk), .reset_n(rst1), .host_valid(hv1), .host_ready(rdy1),
        .host_bank_num(hb1), .host_address(ha1), .host_data(hd1),
        .clear_req(creq1), .clear_active(act1), .opl3_reg_wr(wr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int mc = 0;

    // Reference model state, one slot per instance.
    int         GAP[2] = '{3, 0};
    bit         COR[2] = '{1'b1, 1'b0};
    int         m_cyc[2], m_lastp[2], m_idx[2];
    bit         m_act[2], m_boot[2];
    bit         e_v[2], e_b[2];
    logic [7:0] e_a[2], e_d[2];

    hw_t q0[$], q1[$];
    bit  rnd0 = 0, rnd1 = 0;

    // u0 pulse monitor
    int           n0, fp0, lp0;
    int           pcq[$];
    opl3_reg_wr_t firstw0, lastw0;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, mc);
        end
    endtask

    function automatic bit m_slot(input int i);
        return !m_boot[i] && (GAP[i] == 0 || (m_cyc[i] - m_lastp[i]) >= GAP[i]);
    endfunction

    task automatic m_reset(input int i);
        m_boot[i]  = 1'b1;
        m_act[i]   = COR[i];
        m_idx[i]   = 0;
        e_v[i]     = 1'b0;
        e_b[i]     = 1'b0;
        e_a[i]     = 8'h00;
        e_d[i]     = 8'h00;
        m_lastp[i] = m_cyc[i] - 1000;
    endtask

    // Advance model i by one clock using the inputs that will be sampled at that edge.
    task automatic m_adv(input int i, input bit rstn, input bit hv, input bit hb,
                         input logic [7:0] ha, input logic [7:0] hd, input bit creq);
        bit s, act_cur;
        if (!rstn) begin
            m_cyc[i]++;
            m_reset(i);
            return;
        end
        s       = m_slot(i);
        act_cur = m_act[i];
        e_v[i]  = 1'b0;
        if (m_boot[i]) begin
            m_boot[i] = 1'b0;
        end else if (s) begin
            if (act_cur) begin
                e_v[i] = 1'b1;
                e_b[i] = (m_idx[i] >= 256);
                e_a[i] = 8'(m_idx[i] % 256);
                e_d[i] = 8'h00;
                if (m_idx[i] == 511) m_act[i] = 1'b0;
                m_idx[i] = (m_idx[i] + 1) % 512;
            end else if (hv) begin
                e_v[i] = 1'b1;
                e_b[i] = hb;
                e_a[i] = ha;
                e_d[i] = hd;
            end
        end
        if (!act_cur && creq) begin
            m_act[i] = 1'b1;
            m_idx[i] = 0;
        end
        m_cyc[i]++;
        if (e_v[i]) m_lastp[i] = m_cyc[i];
    endtask

    task automatic check_inst(input int i, input opl3_reg_wr_t w, input logic r, input logic a);
        chk($sformatf("u%0d.valid", i), w.valid, e_v[i]);
        if (e_v[i]) begin
            chk($sformatf("u%0d.bank", i), w.bank_num, e_b[i]);
            chk($sformatf("u%0d.addr", i), w.address, e_a[i]);
            chk($sformatf("u%0d.data", i), w.data, e_d[i]);
        end
        chk($sformatf("u%0d.host_ready", i), r, m_slot(i) && !m_act[i]);
        chk($sformatf("u%0d.clear_active", i), a, m_act[i]);
    endtask

    function automatic hw_t rand_hw();
        hw_t h;
        h.b = 1'($urandom_range(0, 1));
        h.a = 8'($urandom);
        h.d = 8'($urandom);
        return h;
    endfunction

    // One clock: drive inputs, advance models, sample #1 after the edge, compare.
    task automatic cycle();
        bit  hs0, hs1;
        hw_t h;
        if (rnd0 && q0.size() == 0 && $urandom_range(0, 3) == 0) q0.push_back(rand_hw());
        if (rnd1 && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_hw());
        if (rnd0 && $urandom_range(0, 599) == 0) creq0 = 1'b1;
        if (rnd1 && $urandom_range(0, 299) == 0) creq1 = 1'b1;
        if (q0.size() > 0) begin
            h = q0[0]; hv0 = 1'b1;
        end else begin
            h = rand_hw(); hv0 = 1'b0;
        end
        hb0 = h.b; ha0 = h.a; hd0 = h.d;
        if (q1.size() > 0) begin
            h = q1[0]; hv1 = 1'b1;
        end else begin
            h = rand_hw(); hv1 = 1'b0;
        end
        hb1 = h.b; ha1 = h.a; hd1 = h.d;
        hs0 = rst0 && rdy0 && hv0;
        hs1 = rst1 && rdy1 && hv1;
        m_adv(0, rst0, hv0, hb0, ha0, hd0, creq0);
        m_adv(1, rst1, hv1, hb1, ha1, hd1, creq1);
        @(posedge clk);
        #1;
        mc++;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        creq0 = 1'b0;
        creq1 = 1'b0;
        check_inst(0, wr0, rdy0, act0);
        check_inst(1, wr1, rdy1, act1);
        if (wr0.valid) begin
            if (n0 == 0) begin
                fp0 = mc; firstw0 = wr0;
            end
            n0++;
            lp0 = mc;
            lastw0 = wr0;
            pcq.push_back(mc);
        end
    endtask

    task automatic do_reset0();
        rst0 = 1'b0;
        #1;
        chk("rst_mid.valid", wr0.valid, 1'b0);
        chk("rst_mid.clear_active", act0, 1'b1);
        chk("rst_mid.host_ready", rdy0, 1'b0);
        m_reset(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit sent;
        int lp_clear;
        hw_t h;

        tbl[0] = '{1'b0, 8'h20, 8'h11, 1'b1, 1'b0, 8'h20, 8'h11, 1'b1};
        tbl[1] = '{1'b1, 8'h05, 8'h22, 1'b1, 1'b1, 8'h05, 8'h22, 1'b1};
        tbl[2] = '{1'b0, 8'hA0, 8'h33, 1'b1, 1'b0, 8'hA0, 8'h33, 1'b1};
        tbl[3] = '{1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 8'h01, 8'hFF, 1'b1, 1'b0, 8'h01, 8'hFF, 1'b1};

        rst0 = 1'b0; rst1 = 1'b0;
        hv0 = 0; hb0 = 0; ha0 = 0; hd0 = 0; creq0 = 0;
        hv1 = 0; hb1 = 0; ha1 = 0; hd1 = 0; creq1 = 0;
        m_cyc = '{0, 0};
        m_reset(0);
        m_reset(1);
        n0 = 0; fp0 = 0; lp0 = 0;

        // Reset state
        #1;
        chk("reset.u0.valid", wr0.valid, 1'b0);
        chk("reset.u0.fields", {wr0.bank_num, wr0.address, wr0.data}, 17'h0);
        chk("reset.u0.clear_active", act0, 1'b1);
        chk("reset.u0.host_ready", rdy0, 1'b0);
        chk("reset.u1.valid", wr1.valid, 1'b0);
        chk("reset.u1.fields", {wr1.bank_num, wr1.address, wr1.data}, 17'h0);
        chk("reset.u1.clear_active", act1, 1'b0);
        chk("reset.u1.host_ready", rdy1, 1'b0);
        cycle();
        cycle();

        // Release; u0 sweeps with a host write held, u1 takes table writes
        h = '{1'b0, 8'hB0, 8'h20};
        q0.push_back(h);
        rst0 = 1'b1; rst1 = 1'b1;
        cycle();
        chk("u1.ready_after_release", rdy1, 1'b1);
        chk("u1.no_write_after_release", wr1.valid, 1'b0);

        for (int k = 0; k < 5; k++) begin
            h = '{tbl[k].b, tbl[k].a, tbl[k].d};
            q1.push_back(h);
            cycle();
            chk($sformatf("tbl%0d.valid", k), wr1.valid, tbl[k].ev);
            chk($sformatf("tbl%0d.bank", k), wr1.bank_num, tbl[k].eb);
            chk($sformatf("tbl%0d.addr", k), wr1.address, tbl[k].ea);
            chk($sformatf("tbl%0d.data", k), wr1.data, tbl[k].ed);
            chk($sformatf("tbl%0d.ready", k), rdy1, tbl[k].erdy);
        end

        rnd1 = 1;
        for (int c = 0; c < 2500 && act0; c++) cycle();
        chk("sweep1.done", act0, 1'b0);
        chk("sweep1.count", n0, 512);
        chk("sweep1.span", lp0 - fp0, 2044);
        chk("sweep1.first", {firstw0.bank_num, firstw0.address, firstw0.data}, 17'h0_00_00);
        chk("sweep1.last", {lastw0.bank_num, lastw0.address, lastw0.data}, 17'h1_FF_00);

        // Held host write plus two more after the sweep: pulses 4 cycles apart
        lp_clear = lp0;
        h = '{1'b1, 8'hB1, 8'h25}; q0.push_back(h);
        h = '{1'b0, 8'hA0, 8'h41}; q0.push_back(h);
        n0 = 0;
        pcq.delete();
        for (int c = 0; c < 60 && n0 < 3; c++) cycle();
        chk("host3.count", n0, 3);
        if (pcq.size() >= 3) begin
            chk("host3.gap_from_sweep", pcq[0] - lp_clear, 4);
            chk("host3.gap01", pcq[1] - pcq[0], 4);
            chk("host3.gap12", pcq[2] - pcq[1], 4);
        end

        // clear_req in the same cycle as a host handshake
        h = '{1'b0, 8'hB3, 8'h2A};
        q0.push_back(h);
        for (int c = 0; c < 20; c++) begin
            if (rdy0) begin
                creq0 = 1'b1;
                break;
            end
            cycle();
        end
        cycle();
        chk("hs_clr.valid", wr0.valid, 1'b1);
        chk("hs_clr.write", {wr0.bank_num, wr0.address, wr0.data}, 17'h0_B3_2A);
        chk("hs_clr.clear_active", act0, 1'b1);
        n0 = 0;
        sent = 0;
        for (int c = 0; c < 2500 && act0; c++) begin
            if (n0 == 100 && !sent) begin
                creq0 = 1'b1;
                sent = 1;
            end
            cycle();
        end
        chk("sweep2.done", act0, 1'b0);
        chk("sweep2.count", n0, 512);
        chk("sweep2.first", {firstw0.bank_num, firstw0.address, firstw0.data}, 17'h0_00_00);
        chk("sweep2.last", {lastw0.bank_num, lastw0.address, lastw0.data}, 17'h1_FF_00);

        // Reset while the 0x123 clear write is on the bus
        creq0 = 1'b1;
        cycle();
        found = 0;
        for (int c = 0; c < 2500; c++) begin
            cycle();
            if (wr0.valid && wr0.bank_num && wr0.address == 8'h23) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid.found_0x123", found, 1'b1);
        do_reset0();
        cycle();
        cycle();
        rst0 = 1'b1;
        n0 = 0;
        for (int c = 0; c < 20 && n0 == 0; c++) cycle();
        chk("rst_mid.restart_seen", n0, 1);
        chk("rst_mid.restart_first", {firstw0.bank_num, firstw0.address, firstw0.data}, 17'h0_00_00);

        // Randomized traffic on both instances
        rnd0 = 1;
        repeat (3000) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/opl3_reg_wr_sched.md
Name: opl3_reg_wr_sched

Overview:
- Single point that drives the opl3_reg_wr_t register-write bus into the OPL3 core and its register observers (channel/key-on monitors, LED taps).
- Arbitrates between two sources:
  - the host register port (CPU/ISA write decoder);
  - an internal clear sequencer that writes 0x00 to all 512 registers (bank 0 and bank 1, addresses 0x00–0xFF).
- Enforces a programmable minimum spacing between issued writes so downstream per-sample register logic never sees back-to-back updates.

Parameters:
- MIN_GAP, 3, minimum number of idle cycles between two valid pulses on opl3_reg_wr (0 = back-to-back allowed).
- CLEAR_ON_RESET, 1, when 1 a full clear sweep starts automatically after reset release.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset (single clock domain, clk).
- host_valid  in  1  host write request; must be held with stable fields until accepted.
- host_ready  out  1  host write accepted on the clk edge where host_valid && host_ready.
- host_bank_num  in  1  register bank.
- host_address  in  8  register address.
- host_data  in  8  register data.
- clear_req  in  1  single-cycle pulse requesting a full clear sweep.
- clear_active  out  1  high while a sweep is pending or in progress.
- opl3_reg_wr  out  opl3_reg_wr_t  write bus: valid (1), bank_num (1), address (8), data (8); registered.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - opl3_reg_wr all fields 0; host_ready=0; gap counter=0; sweep index=0.
  - clear_active = CLEAR_ON_RESET.
  - Asserting reset mid-sweep or mid-gap aborts immediately; valid drops in the same cycle.
- Gap counter `cnt`, width $clog2(MIN_GAP+1) (min 1):
  - loaded with MIN_GAP in every cycle a valid pulse is driven;
  - otherwise decrements while nonzero.
- Issue slot = cycle with cnt==0 and no valid pulse currently driven (when MIN_GAP=0, cnt==0 alone).
- Arbitration at an issue slot:
  - clear sweep has strict priority over host;
  - an issued write appears on opl3_reg_wr exactly 1 cycle after the slot, with valid high for exactly 1 cycle.
- Resulting throughput: one write per MIN_GAP+1 cycles maximum, i.e. at least MIN_GAP idle cycles between pulses.
- host_ready = issue slot && !clear_active; depends on registers only, never on host_valid.
  - On handshake, capture bank/address/data and drive them next cycle.
- Clear sweep:
  - 9-bit index {bank, address}, counting 0x000 → 0x1FF; data always 0x00.
  - One write per issue slot.
  - clear_active deasserts in the cycle the 0x1FF write is driven.
  - Sweep is complete after 512 writes; the last write appears 1 + 511·(MIN_GAP+1) cycles after the first slot.
- clear_req handling:
  - while idle: clear_active rises the next cycle and the sweep starts at the next issue slot; index restarts at 0.
  - during an active sweep: ignored (no restart, no queuing).
  - in the same cycle as a host handshake: the host write is still issued; the sweep begins at the following slot.
- Host during a sweep: host_ready=0; a held request is serviced at the first slot after clear_active falls.
- Host fields are sampled only on handshake; later changes while not ready have no effect.
- Single state machine, three states:
  - IDLE → CLEAR on clear_req or reset-release with CLEAR_ON_RESET=1;
  - CLEAR → IDLE after issuing index 0x1FF;
  - the gap is tracked by cnt, orthogonal to state.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, MIN_GAP=3 → 512 pulses, one every 4 cycles. First pulse bank0/0x00/0x00, last bank1/0xFF/0x00, 1+511·4=2045 cycles after the first slot. clear_active falls with the last pulse; host_ready=0 throughout.
- After the sweep, host holds valid with writes B0→0x20, B1→0x25, A0→0x41 → valid pulses exactly 4 cycles apart; fields match; each pulse 1 cycle after its handshake.
- MIN_GAP=0, host_valid held for 5 different writes → 5 consecutive-cycle valid pulses; host_ready constantly high.
- clear_req pulsed in the same cycle as a host handshake (bank0, 0xB3, 0x2A) → host write issued first, then the sweep starts at index 0. A second clear_req mid-sweep → still exactly 512 clear writes.
- reset_n asserted while a valid pulse is driven, mid-sweep at index 0x123 → valid=0 the same cycle. After release, sweep restarts at bank0/0x00.
- CLEAR_ON_RESET=0 → no writes after reset; clear_active=0; host_ready=1 on the first cycle after release.
